// File: rtl/mux_rr_scheduler_pkg.sv
// Shared types and default sizes for the round-robin mux scheduler.
// Holds the FSM state enum and default parameter values.
// Build option: MUX_RR_TIMEOUT_EN enables the per-grant hold limit in the top.
package mux_rr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int N_REQ_DEF    = 8;
    localparam int SEL_W_DEF    = 3;
    localparam int HOLD_MAX_DEF = 4;

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Bundle between the requester bank / mux datapath and the scheduler.
// master = requester/mux side, slave = scheduler side.
// Build option: MUX_RR_TIMEOUT_EN (timeout stays 0 when not defined).
interface mux_rr_scheduler_if #(
    parameter int N_REQ = mux_rr_pkg::N_REQ_DEF,
    parameter int SEL_W = mux_rr_pkg::SEL_W_DEF
);
    logic [N_REQ-1:0] req;
    logic             mux_q;
    logic [SEL_W-1:0] sel;
    logic [N_REQ-1:0] grant;
    logic             data_out;
    logic             data_valid;
    logic             timeout;

    modport master (
        output req, mux_q,
        input  sel, grant, data_out, data_valid, timeout
    );

    modport slave (
        input  req, mux_q,
        output sel, grant, data_out, data_valid, timeout
    );
endinterface

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... mod N_REQ.
// Latency: purely combinational.
// Build option: none (MUX_RR_TIMEOUT_EN only affects the top).
module rr_pick
    import mux_rr_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_winner,
    output logic             o_any
);

    // Scan from farthest to nearest offset so the closest set bit to ptr wins;
    // index arithmetic wraps naturally because N_REQ is a power of two.
    always_comb begin
        o_winner = i_ptr;
        o_any    = |i_req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[i_ptr + SEL_W'(k)]) begin
                o_winner = i_ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of the shared 8:1 mux select; grants one requester at a time
// and registers the mux output. Latency: req in IDLE -> grant +1 edge -> data_valid +2.
// Build option MUX_RR_TIMEOUT_EN: forced release after HOLD_MAX grant cycles with a timeout pulse.
module mux_rr_scheduler
    import mux_rr_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int SEL_W    = SEL_W_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    mux_rr_scheduler_if.slave  bus
);

    state_t           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [N_REQ-1:0] r_grant;
    logic             r_data_out;
    logic             r_data_valid;

    logic [SEL_W-1:0] w_winner;
    logic             w_any;
    logic             w_req_held;

`ifdef MUX_RR_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_MAX) + 1;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_timeout;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_req_held = bus.req[r_sel];

    // Scheduler FSM: picks an owner in IDLE, samples the mux while owned, then
    // forces one dead cycle before the next owner so the mux select never glitches mid-use.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_sel        <= '0;
            r_grant      <= '0;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
`ifdef MUX_RR_TIMEOUT_EN
            r_hold_cnt   <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
`ifdef MUX_RR_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_winner;
                        r_grant <= N_REQ'(1) << w_winner;
                        r_state <= GRANT;
`ifdef MUX_RR_TIMEOUT_EN
                        r_hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    r_data_out <= bus.mux_q;
                    if (!w_req_held) begin
                        r_grant      <= '0;
                        r_data_valid <= 1'b0;
                        r_ptr        <= r_sel + SEL_W'(1);
                        r_state      <= RELEASE;
                    end
`ifdef MUX_RR_TIMEOUT_EN
                    // Owner still requesting at its last allowed cycle: evict it.
                    else if (r_hold_cnt == HOLD_W'(HOLD_MAX - 1)) begin
                        r_grant      <= '0;
                        r_data_valid <= 1'b0;
                        r_ptr        <= r_sel + SEL_W'(1);
                        r_state      <= RELEASE;
                        r_timeout    <= 1'b1;
                    end
`endif
                    else begin
                        r_data_valid <= 1'b1;
`ifdef MUX_RR_TIMEOUT_EN
                        r_hold_cnt   <= r_hold_cnt + HOLD_W'(1);
`endif
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel        = r_sel;
    assign bus.grant      = r_grant;
    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
`ifdef MUX_RR_TIMEOUT_EN
    assign bus.timeout    = r_timeout;
`else
    assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: per-cycle vector table plus hand-written
// sequences for round-robin wrap, hold timeout and reset during a grant.
// Build option: MUX_RR_TIMEOUT_EN selects the expected hold behaviour.
module tb_mux_rr_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] mux_data;

    mux_rr_scheduler_if #(.N_REQ(8), .SEL_W(3)) bus ();

    mux_rr_scheduler #(.N_REQ(8), .SEL_W(3), .HOLD_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural 8:1 mux fed by the scheduler's select.
    assign bus.mux_q = mux_data[bus.sel];

    typedef struct {
        logic        rst;
        logic [7:0]  req;
        logic [13:0] exp;   // {sel, grant, data_valid, data_out, timeout}
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic [7:0] req,
                                input logic [2:0] sel, input logic [7:0] gnt,
                                input logic dv, input logic dout);
        vec_t v;
        v.rst = rst;
        v.req = req;
        v.exp = {sel, gnt, dv, dout, 1'b0};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.grant != 8'h00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic       ok;
    logic [2:0] w;
    logic [7:0] oh;

    initial begin
        reset    = 1'b1;
        bus.req  = 8'h00;
        mux_data = 8'b0110_0101;

        //            rst   req    sel   grant  dv    dout
        tbl[0]  = mk(1'b1, 8'hFF, 3'd0, 8'h00, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 8'hFF, 3'd0, 8'h00, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 8'h04, 3'd2, 8'h04, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 8'h04, 3'd2, 8'h04, 1'b1, 1'b1);
        tbl[5]  = mk(1'b0, 8'h04, 3'd2, 8'h04, 1'b1, 1'b1);
        tbl[6]  = mk(1'b0, 8'h00, 3'd2, 8'h00, 1'b0, 1'b1);
        tbl[7]  = mk(1'b0, 8'h00, 3'd2, 8'h00, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 8'h00, 3'd2, 8'h00, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 8'h20, 3'd5, 8'h20, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 8'h20, 3'd5, 8'h20, 1'b1, 1'b1);
        tbl[11] = mk(1'b0, 8'h03, 3'd5, 8'h00, 1'b0, 1'b1);
        tbl[12] = mk(1'b0, 8'h03, 3'd5, 8'h00, 1'b0, 1'b1);
        tbl[13] = mk(1'b0, 8'h03, 3'd0, 8'h01, 1'b0, 1'b1);
        tbl[14] = mk(1'b0, 8'h03, 3'd0, 8'h01, 1'b1, 1'b1);
        tbl[15] = mk(1'b0, 8'h02, 3'd0, 8'h00, 1'b0, 1'b1);
        tbl[16] = mk(1'b0, 8'h02, 3'd0, 8'h00, 1'b0, 1'b1);
        tbl[17] = mk(1'b0, 8'h02, 3'd1, 8'h02, 1'b0, 1'b1);
        tbl[18] = mk(1'b0, 8'h02, 3'd1, 8'h02, 1'b1, 1'b0);
        tbl[19] = mk(1'b0, 8'h00, 3'd1, 8'h00, 1'b0, 1'b0);
        tbl[20] = mk(1'b0, 8'h00, 3'd1, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            reset   = tbl[i].rst;
            bus.req = tbl[i].req;
            tick();
            chk($sformatf("vec%0d", i),
                {2'b00, bus.sel, bus.grant, bus.data_valid, bus.data_out, bus.timeout},
                {2'b00, tbl[i].exp});
        end

        // Round-robin wrap: all requesting, each owner drops 3 cycles after grant.
        do_reset();
        bus.req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            w  = 3'(n % 8);
            oh = 8'd1 << w;
            wait_grant(ok);
            chk($sformatf("rr_grant%0d", n), {4'h0, ok, bus.sel, bus.grant}, {4'h0, 1'b1, w, oh});
            tick();
            tick();
            bus.req[w] = 1'b0;
            tick();
            chk($sformatf("rr_release%0d", n), {8'h00, bus.grant}, 16'h0000);
            bus.req[w] = 1'b1;
        end

        // Long hold by requester 3.
        do_reset();
        bus.req = 8'h08;
        tick();
        chk("hold_entry", {5'h0, bus.sel, bus.grant}, {5'h0, 3'd3, 8'h08});
`ifdef MUX_RR_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_cyc%0d", k), {7'h0, bus.timeout, bus.grant}, {7'h0, 1'b0, 8'h08});
        end
        tick();
        chk("tmo_release", {6'h0, bus.data_valid, bus.timeout, bus.grant}, {6'h0, 1'b0, 1'b1, 8'h00});
        tick();
        chk("tmo_pulse_end", {7'h0, bus.timeout, bus.grant}, 16'h0000);
        tick();
        chk("tmo_regrant", {5'h0, bus.sel, bus.grant}, {5'h0, 3'd3, 8'h08});
`else
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("hold_cyc%0d", k), {7'h0, bus.timeout, bus.grant}, {7'h0, 1'b0, 8'h08});
        end
`endif
        bus.req = 8'h00;
        tick();
        tick();

        // Reset during a grant must also reset the round-robin pointer.
        do_reset();
        bus.req = 8'h04;
        tick();
        tick();
        bus.req = 8'h00;
        tick();
        tick();
        bus.req = 8'h10;
        tick();
        chk("mid_grant", {8'h00, bus.grant}, {8'h00, 8'h10});
        tick();
        chk("mid_valid", {15'h0, bus.data_valid}, 16'h0001);
        reset = 1'b1;
        tick();
        chk("mid_reset", {4'h0, bus.data_valid, bus.sel, bus.grant}, 16'h0000);
        reset   = 1'b0;
        bus.req = 8'h81;
        tick();
        chk("post_reset_pick", {5'h0, bus.sel, bus.grant}, {5'h0, 3'd0, 8'h01});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
